// File: rtl/dsk_word_fetcher.sv
// dsk_word_fetcher: fetches disk-image words in this drive's read slot and queues big-endian bytes in a FWFT FIFO
module dsk_word_fetcher #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    _reset,
    input  logic                    dskReadAck,
    input  logic                    memoryLatch,
    input  logic [15:0]             memoryDataIn,
    output logic [21:0]             dskReadAddr,
    input  logic                    seek,
    input  logic [19:0]             seekAddr,
    input  logic                    pop,
    output logic [7:0]              byteOut,
    output logic                    byteValid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = 1;

    logic [19:0]   ptr;
    logic [19:0]   ptr_nxt;
    logic [18:0]   addr;
    logic          skip_hi;
    logic          slot_void;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          accept;
    logic          push_word;
    logic          push_low;
    logic          do_pop;
    logic [AW:0]   n_push;
    logic [AW:0]   n_pop;

    assign accept      = dskReadAck && memoryLatch && !slot_void && !seek;
    assign push_word   = accept && !skip_hi && int'(level) <= DEPTH - 2;
    assign push_low    = accept && skip_hi && int'(level) <= DEPTH - 1;
    assign byteValid   = level != '0;
    assign do_pop      = pop && byteValid && !seek;
    assign n_push      = {{(AW-1){1'b0}}, push_word, push_low};
    assign n_pop       = {{AW{1'b0}}, do_pop};
    assign byteOut     = byteValid ? mem[rd_idx] : 8'h00;
    assign dskReadAddr = {2'b00, addr, 1'b0};

    // Pointer advances by the number of bytes actually queued; a dropped word is re-read next slot
    always_comb ptr_nxt = seek ? seekAddr : push_word ? ptr + 20'd2 : push_low ? ptr + 20'd1 : ptr;

    // Fetch pointer, presented address and slot bookkeeping; address only moves outside a live window or on capture
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ptr       <= '0;
            addr      <= '0;
            skip_hi   <= 1'b0;
            slot_void <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            addr      <= (!dskReadAck || accept) ? ptr_nxt[19:1] : addr;
            skip_hi   <= seek ? seekAddr[0] : push_low ? 1'b0 : skip_hi;
            slot_void <= seek ? dskReadAck : dskReadAck && slot_void;
            underrun  <= pop && !byteValid && !seek;
        end
    end

    // FIFO indices and occupancy; seek flushes everything
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            level  <= '0;
        end else begin
            wr_idx <= seek ? '0 : wr_idx + n_push[AW-1:0];
            rd_idx <= seek ? '0 : rd_idx + n_pop[AW-1:0];
            level  <= seek ? '0 : level + n_push - n_pop;
        end
    end

    // Byte storage: high byte first, or just the low byte when resuming at an odd offset
    always_ff @(posedge clk) begin
        if (push_word) begin
            mem[wr_idx]           <= memoryDataIn[15:8];
            mem[wr_idx + IDX_ONE] <= memoryDataIn[7:0];
        end else if (push_low) begin
            mem[wr_idx] <= memoryDataIn[7:0];
        end
    end
endmodule

// File: tb/tb_dsk_word_fetcher.sv
// tb_dsk_word_fetcher: directed scoreboard bench for the disk word fetcher
module tb_dsk_word_fetcher;
    localparam int DEPTH = 8;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dskReadAck = 1'b0;
    logic          memoryLatch = 1'b0;
    logic [15:0]   memoryDataIn = '0;
    logic [21:0]   dskReadAddr;
    logic          seek = 1'b0;
    logic [19:0]   seekAddr = '0;
    logic          pop = 1'b0;
    logic [7:0]    byteOut;
    logic          byteValid;
    logic [LW-1:0] level;
    logic          underrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    dsk_word_fetcher #(.DEPTH(DEPTH)) dut (
        .clk(clk), ._reset(rst_n), .dskReadAck(dskReadAck), .memoryLatch(memoryLatch),
        .memoryDataIn(memoryDataIn), .dskReadAddr(dskReadAddr), .seek(seek), .seekAddr(seekAddr),
        .pop(pop), .byteOut(byteOut), .byteValid(byteValid), .level(level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_seek(input logic [19:0] a);
        seekAddr = a;
        seek = 1'b1;
        @(negedge clk);
        seek = 1'b0;
    endtask

    task automatic slot(input logic [15:0] w);
        dskReadAck = 1'b1;
        memoryDataIn = w;
        repeat (3) @(negedge clk);
        memoryLatch = 1'b1;
        @(negedge clk);
        memoryLatch = 1'b0;
        dskReadAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            chk("head", {24'h0, byteOut}, {24'h0, exp_q.pop_front()});
            pop = 1'b1;
            @(negedge clk);
            pop = 1'b0;
        end
        chk("drained_level", 32'(level), 0);
        chk("drained_valid", 32'(byteValid), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(dskReadAddr), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(byteValid), 0);
        chk("rst_byte", 32'(byteOut), 0);
        chk("rst_underrun", 32'(underrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_seek(20'h00010);
        chk("seek10_addr", 32'(dskReadAddr), 32'h10);
        chk("seek10_level", 32'(level), 0);
        slot(16'hA55A);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        chk("a55a_level", 32'(level), 2);
        chk("a55a_addr", 32'(dskReadAddr), 32'h12);
        drain();

        do_seek(20'h00011);
        chk("seek11_addr", 32'(dskReadAddr), 32'h10);
        slot(16'h1234);
        exp_q.push_back(8'h34);
        chk("odd_level", 32'(level), 1);
        chk("odd_addr", 32'(dskReadAddr), 32'h12);
        drain();

        do_seek(20'h00021);
        slot(16'h0011);
        exp_q.push_back(8'h11);
        slot(16'h2233);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        slot(16'h4455);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        slot(16'h6677);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        chk("fill_level", 32'(level), DEPTH - 1);
        chk("fill_addr", 32'(dskReadAddr), 32'h28);
        slot(16'hBEEF);
        chk("nospace_level", 32'(level), DEPTH - 1);
        chk("nospace_addr", 32'(dskReadAddr), 32'h28);
        chk("one_pop_head", {24'h0, byteOut}, {24'h0, exp_q.pop_front()});
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        slot(16'hBEEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        chk("retry_level", 32'(level), DEPTH);
        chk("retry_addr", 32'(dskReadAddr), 32'h2A);
        drain();

        slot(16'h5555);
        chk("pre_flush_level", 32'(level), 2);
        dskReadAck = 1'b1;
        memoryDataIn = 16'hDEAD;
        @(negedge clk);
        seekAddr = 20'h00100;
        seek = 1'b1;
        @(negedge clk);
        seek = 1'b0;
        chk("midwin_addr_stable", 32'(dskReadAddr), 32'h2C);
        chk("midwin_flush", 32'(level), 0);
        @(negedge clk);
        memoryLatch = 1'b1;
        @(negedge clk);
        memoryLatch = 1'b0;
        dskReadAck = 1'b0;
        chk("void_level", 32'(level), 0);
        chk("void_valid", 32'(byteValid), 0);
        @(negedge clk);
        chk("post_void_addr", 32'(dskReadAddr), 32'h100);
        slot(16'hCAFE);
        exp_q.push_back(8'hCA);
        exp_q.push_back(8'hFE);
        chk("cafe_addr", 32'(dskReadAddr), 32'h102);
        drain();

        do_seek(20'hFFFFE);
        chk("wrap_addr0", 32'(dskReadAddr), 32'h0FFFFE);
        slot(16'h0102);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        chk("wrap_addr1", 32'(dskReadAddr), 32'h000000);
        slot(16'h0304);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        chk("wrap_addr2", 32'(dskReadAddr), 32'h000002);
        drain();

        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        chk("underrun_hi", 32'(underrun), 1);
        chk("underrun_level", 32'(level), 0);
        @(negedge clk);
        chk("underrun_lo", 32'(underrun), 0);

        do_seek(20'h00031);
        slot(16'h0A0B);
        exp_q.push_back(8'h0B);
        slot(16'h0C0D);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h0D);
        chk("lvl3", 32'(level), 3);
        dskReadAck = 1'b1;
        memoryDataIn = 16'h0E0F;
        repeat (3) @(negedge clk);
        chk("pp_head", {24'h0, byteOut}, {24'h0, exp_q.pop_front()});
        memoryLatch = 1'b1;
        pop = 1'b1;
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'h0F);
        @(negedge clk);
        memoryLatch = 1'b0;
        pop = 1'b0;
        dskReadAck = 1'b0;
        chk("pushpop_level", 32'(level), 4);
        @(negedge clk);
        drain();

        seekAddr = 20'h00040;
        seek = 1'b1;
        pop = 1'b1;
        @(negedge clk);
        seek = 1'b0;
        pop = 1'b0;
        chk("seek_pop_no_underrun", 32'(underrun), 0);
        chk("seek_pop_addr", 32'(dskReadAddr), 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsk_word_fetcher.md
# dsk_word_fetcher

Client-side responder for the floppy-image read slot issued by the address controller. It presents a word-aligned image address on `dskReadAddr` and captures the RAM word on `memoryDataIn` when its slot's `dskReadAck` coincides with `memoryLatch`. It splits each word into big-endian bytes and queues them in a small first-word-fall-through (FWFT) FIFO for the IWM/floppy emulation to consume. One instance serves the internal drive (`dskReadAckInt`) and one serves the external drive (`dskReadAckExt`); the controller adds the image base offset itself.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, at least 4.

Ports:
- clk  in  1  system clock (same clock as the bus-phase counter)
- _reset  in  1  asynchronous, active-low reset
- dskReadAck  in  1  this drive's slot grant from the controller; high for 4 consecutive clk cycles per slot
- memoryLatch  in  1  one-clk strobe on the last clk of every bus cycle; read data is valid here
- memoryDataIn  in  16  RAM read data; bits [15:8] are the byte at the even address
- dskReadAddr  out  22  byte address within the image, `{2'b00, ptr[19:1], 1'b0}`
- seek  in  1  one-clk pulse: flush the FIFO and restart fetching at `seekAddr`
- seekAddr  in  20  byte offset within the 1 MB image
- pop  in  1  consumer takes the head byte this cycle
- byteOut  out  8  FIFO head byte (FWFT)
- byteValid  out  1  FIFO not empty
- level  out  $clog2(DEPTH)+1  bytes currently held
- underrun  out  1  one-clk pulse when `pop` is asserted while the FIFO is empty

## Operation
- State:
  - `ptr[19:0]`, the fetch byte pointer.
  - `skipHi`, set when the seek target is odd.
  - `slotVoid`, which invalidates the remainder of the current ack window.
  - The byte FIFO: DEPTH entries with read/write indices and a count.
- Word acceptance happens at `dskReadAck && memoryLatch && !slotVoid && !seek`. At that point:
  - If `skipHi=0` and free ≥ 2: push `memoryDataIn[15:8]`, then `[7:0]`; `ptr += 2`.
  - If `skipHi=1` and free ≥ 1: push `memoryDataIn[7:0]` only; clear `skipHi`; `ptr += 1`, which leaves it even.
  - If there is insufficient space, the word is dropped and `ptr` is unchanged. The same address is re-read at the next slot.
- Free space is computed from `level` before this cycle's pop. A simultaneous push and pop is legal, and `level` changes by pushes minus pops.
- `seek`:
  - Sets `ptr <= seekAddr`, `skipHi <= seekAddr[0]`, and `level <= 0`.
  - Sets `slotVoid <= dskReadAck`. `slotVoid` clears when `dskReadAck` is low.
  - A `pop` in the same cycle is ignored and does not raise `underrun`.
- Pointer arithmetic is modulo 2^20. After 0xFFFFE, the pointer wraps to 0x00000; `dskReadAddr` never exceeds 0x0FFFFE.
- `pop` while empty leaves the state unchanged and pulses `underrun`.
- `dskReadAddr` changes only on a clk edge where `dskReadAck` is low, or on the acceptance edge itself. It is stable throughout any window that is used for capture.

## Timing
- Reset values:
  - `ptr=0`, `dskReadAddr=0`.
  - `level=0`, `byteValid=0`, `byteOut=0x00`.
  - `underrun=0`, `skipHi=0`, `slotVoid=0`.
- Bytes pushed on edge N are visible on `byteOut`/`byteValid` after edge N. The high byte arrives first; the low byte appears at the head after the high byte is popped.
- The updated `dskReadAddr` is visible the cycle after the accepting `memoryLatch`, before the next slot.
- Throughput is at most one word per granted slot. `seek` overrides acceptance on the same edge.
- Deasserting reset mid-slot restarts fetching from 0 at the next full ack window. A partial window is never captured unless it contains `memoryLatch`.

## Test plan
- Reset, then `seek` to 0x00010 with RAM[0x00010]=0xA55A; grant a slot. Required: `byteOut`=0xA5, then 0x5A after one pop; `dskReadAddr`=0x000012; `level` goes 0→2.
- `seek` to 0x00011 with word 0x1234. Required: only 0x34 is queued; `level`=1; the next address is 0x000012.
- Fill the FIFO to DEPTH-1 (no pops) and grant a slot. Required: no push, and `dskReadAddr` unchanged. Pop one byte and grant the next slot: the same word is accepted.
- Assert `seek` to 0x00100 during clk 2 of an ack window. Required: that window's word is discarded, the FIFO is empty, and the next window reads 0x000100.
- `seek` to 0xFFFFE and grant two slots. Required: the addresses presented are 0x0FFFFE, then 0x000000.
- `pop` on an empty FIFO. Required: `underrun` is high for exactly 1 clk and `level` stays 0. Simultaneous push and pop at `level`=3 results in `level`=4.
